if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Parametrised instruction-fetch stage for the pipelined core. It holds the program counter and fetches from an on-chip instruction memory. The memory is loadable through a write port. The fetched word is registered into the IF/ID pipeline register. Over the previous single-width PC/memory fetch, it adds stall, flush, branch redirect, a valid bit and configurable widths, depth, step and reset vector.

Parameters:
ADDR_W, 8, PC width; instruction memory depth is 2**ADDR_W words
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, sequential PC increment in words
NOP_INSTR, 0, INSTR_W-bit value written into if_id_instr on reset/bubble

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall_i  input  1  hold PC and IF/ID register (hazard from ID)
flush_i  input  1  insert bubble into IF/ID this cycle
redirect_valid_i  input  1  branch/jump taken; load redirect_pc_i
redirect_pc_i  input  ADDR_W  redirect target
imem_we_i  input  1  instruction memory write enable
imem_waddr_i  input  ADDR_W  write address
imem_wdata_i  input  INSTR_W  write data
pc_o  output  ADDR_W  current PC (address being fetched)
if_id_valid_o  output  1  IF/ID holds a real instruction
if_id_pc_o  output  ADDR_W  PC of instruction in IF/ID
if_id_instr_o  output  INSTR_W  instruction in IF/ID

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, no clock needed):
  - pc_o = RESET_PC
  - if_id_valid_o = 0, if_id_pc_o = 0, if_id_instr_o = NOP_INSTR
  - Memory contents are not cleared.
- Fetch read is combinational: fetch_word = imem[pc_o].
- PC update at each rising edge. Priority is redirect > stall > advance.
  - redirect_valid_i=1: pc <= redirect_pc_i. This applies even when stall_i=1.
  - else stall_i=1: pc holds.
  - else pc <= (pc + PC_STEP) mod 2**ADDR_W. Wrap-around is silent, no flag.
- IF/ID update at each rising edge. Priority is (redirect or flush) > stall > capture.
  - redirect_valid_i=1 or flush_i=1: valid <= 0, instr <= NOP_INSTR, pc field <= 0. This squashes the wrong-path fetch and applies even when stall_i=1.
  - else stall_i=1: all IF/ID fields hold.
  - else valid <= 1, if_id_pc <= pc, if_id_instr <= fetch_word.
- Latency:
  - An instruction at address A appears on if_id_* one edge after pc_o==A with no stall.
  - After a redirect to T: pc_o=T after the redirect edge; if_id shows a bubble for that edge; T's instruction appears one edge later.
- flush_i alone does not change the PC; the PC advances or stalls normally.
- Memory write is synchronous on the rising edge when imem_we_i=1.
  - Same-edge write to address == pc_o: IF/ID captures the OLD word.
  - The new word is visible combinationally after that edge.
- After reset release, the first edge with no stall, flush or redirect captures imem[RESET_PC] with valid=1.
- Reset asserted mid-stall or mid-redirect overrides everything immediately.
- X on stall_i, flush_i or redirect_valid_i while rst=0 is illegal. Assertion: these inputs are never X out of reset.

Test Plan:
1. Sequential fetch: load imem[0..3]=0x11,0x22,0x33,0x44; release rst → pc_o goes 0,1,2,3 on successive edges; if_id_instr 0x11,0x22,0x33 with valid=1 and if_id_pc 0,1,2, each one edge behind pc_o.
2. Stall: with pc_o=2, assert stall_i for 3 cycles → pc_o stays 2 and if_id (pc=1, instr=0x22, valid=1) held; deassert → next edge captures pc=2 / 0x33.
3. Redirect with stall: pc_o=5, stall_i=1 and redirect_valid_i=1 with target 0x40 together → next edge pc_o=0x40 and if_id_valid=0 with instr=NOP_INSTR; following edge captures imem[0x40], valid=1.
4. Wrap and flush:
   - ADDR_W=8, PC_STEP=1, pc_o=0xFF → next edge pc_o=0x00.
   - flush_i pulse at pc_o=0x10 → bubble in IF/ID; PC still advances to 0x11.
5. Write/read hazard: pc_o=7, write imem[7]=0xDEAD_BEEF in the same cycle (old word 0x77) → IF/ID captures 0x77; after a redirect back to 7, the next capture reads 0xDEAD_BEEF.
6. Asynchronous reset mid-run: assert rst between clock edges at pc_o=0x23 → pc_o=RESET_PC and if_id_valid=0 immediately, with no edge needed; also re-check with RESET_PC=0x80, PC_STEP=4 → pc_o goes 0x80, 0x84, 0x88.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bus: pipeline control, redirect, imem load port and IF/ID outputs.
// The master side drives the controls; the slave side is the fetch stage itself.
interface if_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic               stall_i;
  logic               flush_i;
  logic               redirect_valid_i;
  logic [ADDR_W-1:0]  redirect_pc_i;
  logic               imem_we_i;
  logic [ADDR_W-1:0]  imem_waddr_i;
  logic [INSTR_W-1:0] imem_wdata_i;
  logic [ADDR_W-1:0]  pc_o;
  logic               if_id_valid_o;
  logic [ADDR_W-1:0]  if_id_pc_o;
  logic [INSTR_W-1:0] if_id_instr_o;

  modport master (
    output stall_i, flush_i, redirect_valid_i, redirect_pc_i,
    output imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, if_id_valid_o, if_id_pc_o, if_id_instr_o
  );

  modport slave (
    input  stall_i, flush_i, redirect_valid_i, redirect_pc_i,
    input  imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, if_id_valid_o, if_id_pc_o, if_id_instr_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, loadable instruction memory and the
// IF/ID pipeline register, with stall, flush and branch redirect.
module if_stage #(
  parameter int                 ADDR_W    = 8,
  parameter int                 INSTR_W   = 32,
  parameter int                 RESET_PC  = 0,
  parameter int                 PC_STEP   = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.slave    io_fetch
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

  logic [INSTR_W-1:0] r_imem [DEPTH];
  logic [ADDR_W-1:0]  r_pc;
  logic               r_ifIdValid;
  logic [ADDR_W-1:0]  r_ifIdPc;
  logic [INSTR_W-1:0] r_ifIdInstr;
  logic [INSTR_W-1:0] w_fetchWord;
  logic               w_squash;

  // Memory is deliberately left out of reset so a program loaded during reset survives.
  always_ff @(posedge clk) begin
    if (io_fetch.imem_we_i) begin
      r_imem[io_fetch.imem_waddr_i] <= io_fetch.imem_wdata_i;
    end
  end

  assign w_fetchWord = r_imem[r_pc];
  assign w_squash    = io_fetch.redirect_valid_i | io_fetch.flush_i;

  // A taken redirect must win over a stall, otherwise the branch would be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= PC_INIT;
    end else if (io_fetch.redirect_valid_i) begin
      r_pc <= io_fetch.redirect_pc_i;
    end else if (!io_fetch.stall_i) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifIdValid <= 1'b0;
      r_ifIdPc    <= '0;
      r_ifIdInstr <= NOP_INSTR;
    end else if (w_squash) begin
      r_ifIdValid <= 1'b0;
      r_ifIdPc    <= '0;
      r_ifIdInstr <= NOP_INSTR;
    end else if (!io_fetch.stall_i) begin
      r_ifIdValid <= 1'b1;
      r_ifIdPc    <= r_pc;
      r_ifIdInstr <= w_fetchWord;
    end
  end

  assign io_fetch.pc_o          = r_pc;
  assign io_fetch.if_id_valid_o = r_ifIdValid;
  assign io_fetch.if_id_pc_o    = r_ifIdPc;
  assign io_fetch.if_id_instr_o = r_ifIdInstr;

  // Pipeline controls must be driven to known values whenever reset is released.
  assert property (@(posedge clk) disable iff (rst)
    !$isunknown({io_fetch.stall_i, io_fetch.flush_i, io_fetch.redirect_valid_i}));

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, async-reset sequences, a second
// instance with a non-zero reset vector and step, and random traffic against a model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  if_stage_if #(.ADDR_W(8), .INSTR_W(32)) bus  ();
  if_stage_if #(.ADDR_W(8), .INSTR_W(32)) bus2 ();

  if_stage #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(0), .PC_STEP(1), .NOP_INSTR(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_fetch (bus)
  );

  if_stage #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h80), .PC_STEP(4), .NOP_INSTR(NOP)) dut2 (
    .clk      (clk),
    .rst      (rst2),
    .io_fetch (bus2)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [7:0]  rpc;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  ePc;
    logic        eValid;
    logic [7:0]  eIfPc;
    logic [31:0] eInstr;
  } vec_t;

  int passCount = 0;
  int totalCount = 0;

  // Reference model: architectural state of the fetch stage for dut.
  logic [31:0] mMem [256];
  logic [7:0]  mPc;
  logic        mValid;
  logic [7:0]  mIfPc;
  logic [31:0] mInstr;

  function automatic logic [31:0] initWord(input int a);
    case (a)
      0:       return 32'h11;
      1:       return 32'h22;
      2:       return 32'h33;
      3:       return 32'h44;
      7:       return 32'h77;
      default: return 32'hC0DE_0000 | 32'(a);
    endcase
  endfunction

  function automatic vec_t mkVec(input logic st, input logic fl, input logic rd,
                                 input logic [7:0] rpc, input logic we,
                                 input logic [7:0] wa, input logic [31:0] wd,
                                 input logic [7:0] ePc, input logic eV,
                                 input logic [7:0] eIp, input logic [31:0] eI);
    vec_t v;
    v = '{st, fl, rd, rpc, we, wa, wd, ePc, eV, eIp, eI};
    return v;
  endfunction

  task automatic resetModel();
    mPc    = 8'h00;
    mValid = 1'b0;
    mIfPc  = 8'h00;
    mInstr = NOP;
  endtask

  // Entered at a negedge; drives one cycle of inputs, advances the model across
  // the rising edge and returns at the following negedge.
  task automatic applyStimulus(input logic st, input logic fl, input logic rd,
                               input logic [7:0] rpc, input logic we,
                               input logic [7:0] wa, input logic [31:0] wd);
    logic        nValid;
    logic [7:0]  nIfPc;
    logic [31:0] nInstr;
    logic [7:0]  nPc;
    bus.stall_i          = st;
    bus.flush_i          = fl;
    bus.redirect_valid_i = rd;
    bus.redirect_pc_i    = rpc;
    bus.imem_we_i        = we;
    bus.imem_waddr_i     = wa;
    bus.imem_wdata_i     = wd;
    if (rd || fl) begin
      nValid = 1'b0; nIfPc = 8'h00; nInstr = NOP;
    end else if (st) begin
      nValid = mValid; nIfPc = mIfPc; nInstr = mInstr;
    end else begin
      nValid = 1'b1; nIfPc = mPc; nInstr = mMem[mPc];
    end
    if (rd)      nPc = rpc;
    else if (st) nPc = mPc;
    else         nPc = mPc + 8'd1;
    @(posedge clk);
    mPc = nPc; mValid = nValid; mIfPc = nIfPc; mInstr = nInstr;
    if (we) mMem[wa] = wd;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] ePc, input logic eV,
                          input logic [7:0] eIp, input logic [31:0] eI);
    checkOutput({tag, ".pc"},    32'(bus.pc_o),          32'(ePc));
    checkOutput({tag, ".valid"}, 32'(bus.if_id_valid_o), 32'(eV));
    checkOutput({tag, ".ifpc"},  32'(bus.if_id_pc_o),    32'(eIp));
    checkOutput({tag, ".instr"}, bus.if_id_instr_o,      eI);
  endtask

  initial begin
    vec_t vecs[$];
    logic st, fl, rd, we;
    logic [7:0] rpc, wa;
    logic [31:0] wd;

    rst = 1'b1;
    rst2 = 1'b1;
    bus.stall_i = 0; bus.flush_i = 0; bus.redirect_valid_i = 0; bus.redirect_pc_i = 0;
    bus.imem_we_i = 0; bus.imem_waddr_i = 0; bus.imem_wdata_i = 0;
    bus2.stall_i = 0; bus2.flush_i = 0; bus2.redirect_valid_i = 0; bus2.redirect_pc_i = 0;
    bus2.imem_we_i = 0; bus2.imem_waddr_i = 0; bus2.imem_wdata_i = 0;

    // Program load happens while both instances are held in reset.
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bus.imem_we_i  = 1'b1; bus.imem_waddr_i  = 8'(a); bus.imem_wdata_i  = initWord(a);
      bus2.imem_we_i = 1'b1; bus2.imem_waddr_i = 8'(a); bus2.imem_wdata_i = initWord(a);
      mMem[a] = initWord(a);
    end
    @(negedge clk);
    bus.imem_we_i = 1'b0;
    bus2.imem_we_i = 1'b0;
    resetModel();

    checkAll("reset", 8'h00, 1'b0, 8'h00, NOP);
    checkOutput("reset2.pc",    32'(bus2.pc_o), 32'h80);
    checkOutput("reset2.valid", 32'(bus2.if_id_valid_o), 32'h0);

    //               st fl rd rpc    we wa     wd            ePc    v  ifpc   instr
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h01, 1, 8'h00, 32'h11));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h02, 1, 8'h01, 32'h22));
    vecs.push_back(mkVec(1, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h02, 1, 8'h01, 32'h22));
    vecs.push_back(mkVec(1, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h02, 1, 8'h01, 32'h22));
    vecs.push_back(mkVec(1, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h02, 1, 8'h01, 32'h22));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h03, 1, 8'h02, 32'h33));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h04, 1, 8'h03, 32'h44));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h05, 1, 8'h04, 32'hC0DE0004));
    vecs.push_back(mkVec(1, 0, 1, 8'h40, 0, 8'h00, 32'h0,        8'h40, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h41, 1, 8'h40, 32'hC0DE0040));
    vecs.push_back(mkVec(0, 0, 1, 8'hFF, 0, 8'h00, 32'h0,        8'hFF, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h00, 1, 8'hFF, 32'hC0DE00FF));
    vecs.push_back(mkVec(0, 0, 1, 8'h10, 0, 8'h00, 32'h0,        8'h10, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 1, 0, 8'h00, 0, 8'h00, 32'h0,        8'h11, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h12, 1, 8'h11, 32'hC0DE0011));
    vecs.push_back(mkVec(0, 0, 1, 8'h07, 0, 8'h00, 32'h0,        8'h07, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 1, 8'h07, 32'hDEADBEEF, 8'h08, 1, 8'h07, 32'h77));
    vecs.push_back(mkVec(0, 0, 1, 8'h07, 0, 8'h00, 32'h0,        8'h07, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h08, 1, 8'h07, 32'hDEADBEEF));
    vecs.push_back(mkVec(0, 0, 1, 8'h22, 0, 8'h00, 32'h0,        8'h22, 0, 8'h00, NOP));
    vecs.push_back(mkVec(0, 0, 0, 8'h00, 0, 8'h00, 32'h0,        8'h23, 1, 8'h22, 32'hC0DE0022));

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc,
                    vecs[i].we, vecs[i].wa, vecs[i].wd);
      checkAll($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eValid, vecs[i].eIfPc, vecs[i].eInstr);
    end

    // Async reset between edges while a stall and redirect are pending.
    bus.stall_i = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i = 8'h55;
    #2 rst = 1'b1;
    #1 checkAll("asyncRst", 8'h00, 1'b0, 8'h00, NOP);
    resetModel();
    @(negedge clk);
    bus.stall_i = 1'b0;
    bus.redirect_valid_i = 1'b0;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 32'h0);
    checkAll("postRst", 8'h01, 1'b1, 8'h00, 32'h11);

    // Second instance: reset vector 0x80 with a step of 4.
    rst2 = 1'b0;
    checkOutput("step4.pc0", 32'(bus2.pc_o), 32'h80);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 32'h0);
    checkOutput("step4.pc1",    32'(bus2.pc_o),          32'h84);
    checkOutput("step4.valid1", 32'(bus2.if_id_valid_o), 32'h1);
    checkOutput("step4.ifpc1",  32'(bus2.if_id_pc_o),    32'h80);
    checkOutput("step4.instr1", bus2.if_id_instr_o,      32'hC0DE0080);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h00, 32'h0);
    checkOutput("step4.pc2",    32'(bus2.pc_o),          32'h88);
    checkOutput("step4.ifpc2",  32'(bus2.if_id_pc_o),    32'h84);
    checkOutput("step4.instr2", bus2.if_id_instr_o,      32'hC0DE0084);

    // Random traffic against the model, with writes biased toward the fetch address.
    for (int n = 0; n < 300; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = 8'($urandom);
      we  = ($urandom_range(0, 4) == 0);
      wa  = ($urandom_range(0, 2) == 0) ? mPc : 8'($urandom);
      wd  = $urandom;
      applyStimulus(st, fl, rd, rpc, we, wa, wd);
      checkAll($sformatf("rand%0d", n), mPc, mValid, mIfPc, mInstr);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
